// File: rtl/heap_pkg.sv
// Shared definitions for the heap array engine: 8-bit action codes, FSM states
// and default geometry constants.
package heap_pkg;

  typedef enum logic [7:0] {
    ACT_NOP   = 8'd0,
    ACT_CLEAR = 8'd1,
    ACT_ALLOC = 8'd2,
    ACT_FREE  = 8'd3,
    ACT_READ  = 8'd4,
    ACT_WRITE = 8'd5,
    ACT_PUSH  = 8'd6,
    ACT_POP   = 8'd7,
    ACT_SIZE  = 8'd8
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_ARRAYS   = 16;
  localparam int DEF_ELEMENTS = 8;
  localparam int DEF_WIDTH    = 12;

endpackage

// File: rtl/heap_free_list.sv
// Live-array bitmap with a lowest-free-handle priority encoder and a count of
// live arrays. Alloc always takes the handle presented on o_free_handle.
module heap_free_list
  import heap_pkg::*;
#(
  parameter int ARRAYS = DEF_ARRAYS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_alloc,
  input  logic                      i_free,
  input  logic [$clog2(ARRAYS)-1:0] i_handle,
  output logic [ARRAYS-1:0]         o_live,
  output logic                      o_full,
  output logic [$clog2(ARRAYS)-1:0] o_free_handle,
  output logic [$clog2(ARRAYS):0]   o_allocated
);

  localparam int HW = $clog2(ARRAYS);

  logic [HW-1:0] w_free_handle;
  logic [HW:0]   r_count;

  genvar gi;
  generate
    for (gi = 0; gi < ARRAYS; gi++) begin : g_live
      logic r_live;
      always_ff @(posedge clock) begin
        if (reset || i_clear) begin
          r_live <= 1'b0;
        end else if (i_alloc && !o_full && (32'(w_free_handle) == gi)) begin
          r_live <= 1'b1;
        end else if (i_free && (32'(i_handle) == gi)) begin
          r_live <= 1'b0;
        end
      end
      assign o_live[gi] = r_live;
    end
  endgenerate

  // Scan downward so the lowest free index wins.
  always_comb begin
    w_free_handle = '0;
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!o_live[i]) begin
        w_free_handle = HW'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_alloc && !o_full) begin
      r_count <= r_count + (HW + 1)'(1);
    end else if (i_free && o_live[i_handle]) begin
      r_count <= r_count - (HW + 1)'(1);
    end
  end

  assign o_full        = &o_live;
  assign o_free_handle = w_free_handle;
  assign o_allocated   = r_count;

endmodule

// File: rtl/heap_array_engine.sv
// Heap array engine: handle-based arrays with alloc/free, indexed and stack access.
// Optional macro HEAP_BOUNDS_CHECK_EN turns index range violations into errors.
module heap_array_engine
  import heap_pkg::*;
#(
  parameter int ARRAYS   = DEF_ARRAYS,
  parameter int ELEMENTS = DEF_ELEMENTS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [7:0]                  action,
  input  logic [$clog2(ARRAYS)-1:0]   array,
  input  logic [$clog2(ELEMENTS)-1:0] index,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        resp_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        error,
  output logic [$clog2(ARRAYS):0]     allocated
);

  localparam int HW    = $clog2(ARRAYS);
  localparam int IW    = $clog2(ELEMENTS);
  localparam int SW    = $clog2(ELEMENTS + 1);
  localparam int DEPTH = ARRAYS * ELEMENTS;
  localparam int AW    = $clog2(DEPTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_action;
  logic [HW-1:0]    r_array;
  logic [IW-1:0]    r_index;
  logic [WIDTH-1:0] r_in_data;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_out_ram;
  logic             r_error;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_exec;
  logic [ARRAYS-1:0] w_live;
  logic             w_full;
  logic [HW-1:0]    w_free_handle;
  logic             w_live_sel;
  logic [SW-1:0]    w_size [ARRAYS];
  logic [SW-1:0]    w_cur_size;
  logic [IW-1:0]    w_idx;
  logic             w_err;
  logic [WIDTH-1:0] w_out;
  logic             w_out_ram;
  logic             w_mem_we;
  logic             w_mem_re;
  logic [IW-1:0]    w_mem_idx;
  logic [AW-1:0]    w_mem_addr;
  logic             w_size_we;
  logic [HW-1:0]    w_size_sel;
  logic [SW-1:0]    w_size_val;
  logic             w_fl_clear;
  logic             w_fl_alloc;
  logic             w_fl_free;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_exec     = (r_state == ST_EXEC);
  assign w_live_sel = (32'(r_array) < ARRAYS) && w_live[r_array];
  assign w_cur_size = w_size[r_array];
  assign w_idx      = IW'(32'(r_index) % ELEMENTS);
  assign w_mem_addr = AW'(32'(r_array) * ELEMENTS + 32'(w_mem_idx));

  always_comb begin
    w_err      = 1'b0;
    w_out      = '0;
    w_out_ram  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_idx  = w_idx;
    w_size_we  = 1'b0;
    w_size_sel = r_array;
    w_size_val = w_cur_size;
    w_fl_clear = 1'b0;
    w_fl_alloc = 1'b0;
    w_fl_free  = 1'b0;
    case (r_action)
      ACT_NOP: begin
      end
      ACT_CLEAR: w_fl_clear = 1'b1;
      ACT_ALLOC: begin
        if (w_full) begin
          w_err = 1'b1;
        end else begin
          w_fl_alloc = 1'b1;
          w_out      = WIDTH'(w_free_handle);
          w_size_we  = 1'b1;
          w_size_sel = w_free_handle;
          w_size_val = '0;
        end
      end
      ACT_FREE: begin
        if (!w_live_sel) w_err = 1'b1;
        else w_fl_free = 1'b1;
      end
      ACT_READ: begin
        if (!w_live_sel) begin
          w_err = 1'b1;
`ifdef HEAP_BOUNDS_CHECK_EN
        end else if (32'(r_index) >= 32'(w_cur_size)) begin
          w_err = 1'b1;
`endif
        end else begin
          w_mem_re  = 1'b1;
          w_out_ram = 1'b1;
        end
      end
      ACT_WRITE: begin
        if (!w_live_sel) begin
          w_err = 1'b1;
`ifdef HEAP_BOUNDS_CHECK_EN
        end else if (32'(r_index) >= ELEMENTS) begin
          w_err = 1'b1;
`endif
        end else begin
          w_mem_we = 1'b1;
          if (SW'(w_idx) >= w_cur_size) begin
            w_size_we  = 1'b1;
            w_size_val = SW'(w_idx) + SW'(1);
          end
        end
      end
      ACT_PUSH: begin
        if (!w_live_sel || (w_cur_size == SW'(ELEMENTS))) begin
          w_err = 1'b1;
        end else begin
          w_mem_we   = 1'b1;
          w_mem_idx  = IW'(w_cur_size);
          w_size_we  = 1'b1;
          w_size_val = w_cur_size + SW'(1);
        end
      end
      ACT_POP: begin
        if (!w_live_sel || (w_cur_size == '0)) begin
          w_err = 1'b1;
        end else begin
          w_mem_re   = 1'b1;
          w_out_ram  = 1'b1;
          w_mem_idx  = IW'(w_cur_size - SW'(1));
          w_size_we  = 1'b1;
          w_size_val = w_cur_size - SW'(1);
        end
      end
      ACT_SIZE: begin
        if (!w_live_sel) w_err = 1'b1;
        else w_out = WIDTH'(w_cur_size);
      end
      default: w_err = 1'b1;
    endcase
  end

  heap_free_list #(
    .ARRAYS(ARRAYS)
  ) u_free_list (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_exec && w_fl_clear),
    .i_alloc      (w_exec && w_fl_alloc),
    .i_free       (w_exec && w_fl_free),
    .i_handle     (r_array),
    .o_live       (w_live),
    .o_full       (w_full),
    .o_free_handle(w_free_handle),
    .o_allocated  (allocated)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ARRAYS; gi++) begin : g_size
      logic [SW-1:0] r_size;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_size <= '0;
        end else if (w_exec && w_fl_clear) begin
          r_size <= '0;
        end else if (w_exec && w_size_we && (32'(w_size_sel) == gi)) begin
          r_size <= w_size_val;
        end
      end
      assign w_size[gi] = r_size;
    end
  endgenerate

  // Single-port element store; a reset landing on the EXEC edge blocks the write.
  always_ff @(posedge clock) begin
    if (w_exec && !reset) begin
      if (w_mem_we) r_mem[w_mem_addr] <= r_in_data;
      if (w_mem_re) r_rd_data <= r_mem[w_mem_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_action   <= '0;
      r_array    <= '0;
      r_index    <= '0;
      r_in_data  <= '0;
      r_out_data <= '0;
      r_out_ram  <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (req_valid && req_ready) begin
        r_action  <= action;
        r_array   <= array;
        r_index   <= index;
        r_in_data <= in_data;
      end
      if (w_exec) begin
        r_error   <= w_err;
        r_out_ram <= w_out_ram;
        if (!w_out_ram) r_out_data <= w_out;
      end
      // RAM read data only becomes visible in RESP; latch it so it holds afterwards.
      if ((r_state == ST_RESP) && r_out_ram) r_out_data <= r_rd_data;
    end
  end

  assign out_data = ((r_state == ST_RESP) && r_out_ram) ? r_rd_data : r_out_data;
  assign error    = r_error;

endmodule

// File: tb/tb_heap_array_engine.sv
// Scoreboard bench for heap_array_engine: a behavioural model predicts every
// response, a monitor compares whenever resp_valid is seen.
module tb_heap_array_engine;

  localparam int NA = 16;
  localparam int NE = 8;
  localparam int NW = 12;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    action;
  logic [3:0]    array;
  logic [2:0]    index;
  logic [NW-1:0] in_data;
  logic          resp_valid;
  logic [NW-1:0] out_data;
  logic          error;
  logic [4:0]    allocated;

  heap_array_engine #(
    .ARRAYS  (NA),
    .ELEMENTS(NE),
    .WIDTH   (NW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .action    (action),
    .array     (array),
    .index     (index),
    .in_data   (in_data),
    .resp_valid(resp_valid),
    .out_data  (out_data),
    .error     (error),
    .allocated (allocated)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int            op;
    bit            err;
    bit            chk;
    logic [NW-1:0] data;
    int            alloc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  bit            m_live [NA];
  int            m_size [NA];
  logic [NW-1:0] m_mem  [NA][NE];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Behavioural model: the spec's rules applied directly to plain arrays.
  task automatic model_apply(input int act, input int arr, input int idx,
                             input logic [NW-1:0] dat, output exp_t e);
    int h;
    e.op = act; e.err = 0; e.chk = 0; e.data = '0; e.alloc = 0;
    if (act == 0) begin
    end else if (act == 1) begin
      for (int a = 0; a < NA; a++) begin m_live[a] = 0; m_size[a] = 0; end
    end else if (act == 2) begin
      h = -1;
      for (int a = 0; a < NA; a++) if (!m_live[a] && h < 0) h = a;
      if (h < 0) e.err = 1;
      else begin m_live[h] = 1; m_size[h] = 0; e.chk = 1; e.data = NW'(h); end
    end else if (act > 8 || !m_live[arr]) begin
      e.err = 1;
    end else begin
      case (act)
        3: m_live[arr] = 0;
        4: begin
`ifdef HEAP_BOUNDS_CHECK_EN
          if (idx >= m_size[arr]) e.err = 1;
          else begin e.chk = 1; e.data = m_mem[arr][idx % NE]; end
`else
          e.chk = 1; e.data = m_mem[arr][idx % NE];
`endif
        end
        5: begin
          m_mem[arr][idx % NE] = dat;
          if ((idx % NE) + 1 > m_size[arr]) m_size[arr] = (idx % NE) + 1;
        end
        6: begin
          if (m_size[arr] == NE) e.err = 1;
          else begin m_mem[arr][m_size[arr]] = dat; m_size[arr]++; end
        end
        7: begin
          e.chk = 1;
          if (m_size[arr] == 0) begin e.err = 1; e.data = '0; end
          else begin m_size[arr]--; e.data = m_mem[arr][m_size[arr]]; end
        end
        default: begin e.chk = 1; e.data = NW'(m_size[arr]); end
      endcase
    end
    for (int a = 0; a < NA; a++) if (m_live[a]) e.alloc++;
  endtask

  task automatic issue(input int act, input int arr, input int idx,
                       input logic [NW-1:0] dat, input bit track);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    while (!req_ready) begin
      n++;
      if (n > 20) begin
        checks++; fails++;
        $display("FAIL req_ready_timeout got=0 want=1 act=%0d", act);
        return;
      end
      @(negedge clock);
    end
    req_valid = 1'b1;
    action    = 8'(act);
    array     = 4'(arr);
    index     = 3'(idx);
    in_data   = dat;
    if (track) begin
      model_apply(act, arr, idx, dat, e);
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t          e;
    bit            hold_pending;
    logic [NW-1:0] hold_val;
    hold_pending = 0;
    hold_val     = '0;
    forever begin
      @(negedge clock);
      if (hold_pending && !resp_valid) check("out_data_hold", 32'(out_data), 32'(hold_val));
      hold_pending = 0;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_resp got=1 want=0 data=%0h", out_data);
        end else begin
          e = sb.pop_front();
          $display("resp op=%0d err=%0b data=%0h alloc=%0d", e.op, error, out_data, allocated);
          check("error", 32'(error), 32'(e.err));
          if (e.chk) begin
            check("out_data", 32'(out_data), 32'(e.data));
            hold_pending = 1;
            hold_val     = e.data;
          end
          check("allocated", 32'(allocated), 32'(e.alloc));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int r;
    int act;
    int n_resp;
    reset = 1'b1; req_valid = 1'b0; action = '0; array = '0; index = '0; in_data = '0;
    for (int a = 0; a < NA; a++) begin m_live[a] = 0; m_size[a] = 0; end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_allocated", 32'(allocated), 32'd0);

    // Give every element a known value so later reads are defined.
    for (int a = 0; a < NA; a++) issue(2, 0, 0, '0, 1);
    for (int a = 0; a < NA; a++)
      for (int i = 0; i < NE; i++) issue(5, a, i, NW'($urandom), 1);
    issue(1, 0, 0, '0, 1);

    // alloc x3
    for (int k = 0; k < 3; k++) issue(2, 0, 0, '0, 1);
    // stack behaviour on h0
    issue(1, 0, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    issue(6, 0, 0, 12'd5, 1);
    issue(6, 0, 0, 12'd7, 1);
    issue(8, 0, 0, '0, 1);
    issue(7, 0, 0, '0, 1);
    issue(7, 0, 0, '0, 1);
    issue(7, 0, 0, '0, 1);
    // indexed write/read and size growth
    issue(1, 0, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    issue(5, 0, 3, 12'hABC, 1);
    issue(4, 0, 3, '0, 1);
    issue(8, 0, 0, '0, 1);
    // exhaustion, free and reuse
    issue(1, 0, 0, '0, 1);
    for (int k = 0; k < NA + 1; k++) issue(2, 0, 0, '0, 1);
    issue(3, 4, 0, '0, 1);
    issue(3, 4, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    // push to full then overflow
    issue(1, 0, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    for (int k = 0; k < NE + 1; k++) issue(6, 0, 0, NW'(k + 16), 1);
    issue(8, 0, 0, '0, 1);
    // read past size
    issue(1, 0, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    issue(6, 0, 0, 12'h111, 1);
    issue(6, 0, 0, 12'h222, 1);
    issue(4, 0, 5, '0, 1);
    // undefined codes and non-live targets
    issue(9, 0, 0, '0, 1);
    issue(255, 0, 0, '0, 1);
    issue(4, 3, 0, '0, 1);
    issue(6, 3, 0, 12'h1, 1);
    issue(8, 3, 0, '0, 1);
    issue(0, 0, 0, '0, 1);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) act = 1;
      else if (r < 18) act = 2;
      else if (r < 26) act = 3;
      else if (r < 40) act = 4;
      else if (r < 54) act = 5;
      else if (r < 70) act = 6;
      else if (r < 85) act = 7;
      else if (r < 93) act = 8;
      else if (r < 96) act = 0;
      else act = int'($urandom_range(9, 255));
      issue(act, int'($urandom_range(0, NA - 1)), int'($urandom_range(0, NE - 1)),
            NW'($urandom), 1);
    end

    // Reset while a write sits in EXEC: no response, no storage update.
    issue(1, 0, 0, '0, 1);
    issue(2, 0, 0, '0, 1);
    issue(5, 0, 2, 12'h5A5, 1);
    issue(5, 0, 2, 12'h3C3, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < NA; a++) begin m_live[a] = 0; m_size[a] = 0; end
    n_resp = 0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) n_resp++;
    end
    check("abandoned_resp_count", 32'(n_resp), 32'd0);
    check("abandoned_allocated", 32'(allocated), 32'd0);
    issue(2, 0, 0, '0, 1);
    issue(4, 0, 2, '0, 1);
    issue(8, 0, 0, '0, 1);

    r = 0;
    while (sb.size() != 0 && r < 20) begin
      @(negedge clock);
      r++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/heap_array_engine.md
HEAP_ARRAY_ENGINE -- requirements
Module: heap_array_engine

Interface
REQ-001 SHALL have parameter ARRAYS, default 16, meaning number of heap arrays.
REQ-002 SHALL have parameter ELEMENTS, default 8, meaning elements per array.
REQ-003 SHALL have parameter WIDTH, default 12, meaning element width in bits.
REQ-004 SHALL have port clock  input  1  the single clock; every register updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  engine can accept a request.
REQ-008 SHALL have port action  input  8  operation code.
REQ-009 SHALL have port array  input  $clog2(ARRAYS)  target array handle.
REQ-010 SHALL have port index  input  $clog2(ELEMENTS)  element index.
REQ-011 SHALL have port in_data  input  WIDTH  write/push data.
REQ-012 SHALL have port resp_valid  output  1  one-cycle pulse: response present.
REQ-013 SHALL have port out_data  output  WIDTH  read/pop data, allocated handle, or size.
REQ-014 SHALL have port error  output  1  qualified by resp_valid; the request failed.
REQ-015 SHALL have port allocated  output  $clog2(ARRAYS)+1  count of live arrays.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both high; accepted inputs are registered.
REQ-017 SHALL use states IDLE -> EXEC -> RESP -> IDLE; req_ready is high only in IDLE.
REQ-018 SHALL assert resp_valid for exactly one cycle in RESP, two cycles after acceptance; out_data and error hold until the next response.
REQ-019 SHALL decode action codes: 0 nop, 1 clear, 2 alloc, 3 free, 4 read, 5 write, 6 push, 7 pop, 8 size; any other code gives error=1 with no state change.
REQ-020 clear SHALL free all arrays, zero all sizes and set allocated=0.
REQ-021 alloc SHALL return the lowest-numbered free handle in out_data, mark it live and zero its size; when all ARRAYS are live, error=1 and nothing changes.
REQ-022 free SHALL mark a live array free; freeing a free array gives error=1.
REQ-023 read SHALL return element[index]; write SHALL store in_data at element[index] and set size to max(size, index+1).
REQ-024 push SHALL store at element[size] and increment size; push when size==ELEMENTS gives error=1 and no write.
REQ-025 pop SHALL decrement size and return the element at the new size; pop when size==0 gives error=1 and out_data=0.
REQ-026 size SHALL return the array's size, zero-extended to WIDTH.
REQ-027 Any operation except nop, clear, alloc or an undefined code on a non-live array SHALL give error=1 with no state change.
REQ-028 Element storage SHALL have a single port; at most one element access occurs per request.

Reset
REQ-029 On reset the state SHALL be IDLE, with req_ready=1, resp_valid=0, out_data=0, error=0 and allocated=0, and all arrays free with size 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abandon the request with no response and no storage update; element contents need not be cleared.

Configuration
REQ-031 With HEAP_BOUNDS_CHECK_EN defined, read/write with index >= the array's size (read) or index >= ELEMENTS (write) SHALL give error=1 and no write.
REQ-032 Without HEAP_BOUNDS_CHECK_EN, index SHALL be used modulo ELEMENTS, with no error raised for range.

Structure
REQ-033 Package heap_pkg SHALL hold the action enum (8-bit) and default parameter constants.
REQ-034 Sub-module heap_free_list SHALL hold the live bitmap, a lowest-free priority encoder and the allocated counter.

Verification
REQ-035 reset; alloc x3 -> out_data 0, 1, 2; allocated=3; error=0.
REQ-036 alloc h0; push 5, push 7; size -> 2; pop -> 7; pop -> 5; pop -> error=1.
REQ-037 alloc h0; write index 3 data 0xABC; read index 3 -> 0xABC; size -> 4.
REQ-038 alloc 16 times -> 17th alloc error=1; free h4; alloc -> 4.
REQ-039 with HEAP_BOUNDS_CHECK_EN: read index 5 on an array of size 2 -> error=1; without it -> no error.
REQ-040 reset asserted during EXEC of a write -> no resp_valid; after reset, allocated=0.
